// File: rtl/descrambler_if.sv
// Word bus between the deserializer, the descrambler and downstream logic.
// Carries the packet_t payload and a one-cycle valid strobe; no backpressure.
package descrambler_pkg;

  typedef struct packed {
    logic [7:0] field0;
    logic [7:0] field1;
    logic [7:0] field2;
    logic [7:0] field3;
  } packet_t;

endpackage

interface descrambler_if;
  import descrambler_pkg::*;

  packet_t data;
  logic    data_en;

  modport master (output data, output data_en);
  modport slave  (input  data, input  data_en);
endinterface

// File: rtl/descrambler.sv
// Receive-side descrambler: hunts for frame alignment on the field1 marker
// byte, then undoes the bit-0 scrambling of field0/2/3 and forwards words
// with a fixed two-cycle latency.
// Optional build macro DESCRAMBLER_STATS_EN adds slip_cnt and drop_cnt outputs.
module descrambler
  import descrambler_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned LOCK_CNT  = 3,
  parameter int unsigned MISS_MAX  = 2
) (
  input  logic          clk,
  input  logic          rst,
  descrambler_if.slave  bus_s,
  descrambler_if.master bus_m,
`ifdef DESCRAMBLER_STATS_EN
  output logic [15:0]   slip_cnt,
  output logic [15:0]   drop_cnt,
`endif
  output logic          locked
);

  localparam int unsigned CNT_W    = 4;
  localparam logic [4:0]  LOCK_LIM = 5'(LOCK_CNT);
  localparam logic [4:0]  MISS_LIM = 5'(MISS_MAX);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   hit_cnt, hit_nxt;
  logic [CNT_W-1:0]   miss_cnt, miss_nxt;
  logic               match_c;
  logic               fwd_c;
  logic [4:0]         hit_inc_c;
  logic [4:0]         miss_inc_c;
  logic [CNT_W-1:0]   hit_sat_c;
  logic [CNT_W-1:0]   miss_sat_c;

  logic               s1_vld;
  packet_t            s1_data;

  // Undo the transmit scrambling of one byte: bit 0 flips when bit 7 is set.
  function automatic logic [7:0] unscramble(input logic [7:0] b);
    return {b[7:1], b[0] ^ b[7]};
  endfunction

  assign match_c    = (bus_s.data.field1 == SYNC_BYTE);
  assign hit_inc_c  = {1'b0, hit_cnt} + 5'd1;
  assign miss_inc_c = {1'b0, miss_cnt} + 5'd1;
  assign hit_sat_c  = (hit_cnt == {CNT_W{1'b1}}) ? hit_cnt : CNT_W'(hit_inc_c);
  assign miss_sat_c = (miss_cnt == {CNT_W{1'b1}}) ? miss_cnt : CNT_W'(miss_inc_c);

  // Alignment FSM next state, counters and forward decision for the accepted word.
  always_comb begin
    state_nxt = state;
    hit_nxt   = hit_cnt;
    miss_nxt  = miss_cnt;
    fwd_c     = 1'b0;
    if (bus_s.data_en) begin
      case (state)
        HUNT: begin
          if (match_c) begin
            if (LOCK_LIM <= 5'd1) begin
              state_nxt = LOCKED;
              hit_nxt   = '0;
              miss_nxt  = '0;
            end else begin
              state_nxt = CONFIRM;
              hit_nxt   = CNT_W'(1);
            end
          end
        end
        CONFIRM: begin
          if (match_c) begin
            if (hit_inc_c >= LOCK_LIM) begin
              state_nxt = LOCKED;
              hit_nxt   = '0;
              miss_nxt  = '0;
            end else begin
              hit_nxt = hit_sat_c;
            end
          end else begin
            state_nxt = HUNT;
            hit_nxt   = '0;
          end
        end
        LOCKED: begin
          if (match_c) begin
            miss_nxt = '0;
            fwd_c    = 1'b1;
          end else if (miss_inc_c >= MISS_LIM) begin
            state_nxt = HUNT;
            miss_nxt  = '0;
          end else begin
            miss_nxt = miss_sat_c;
            fwd_c    = 1'b1;
          end
        end
        default: begin
          state_nxt = HUNT;
          hit_nxt   = '0;
          miss_nxt  = '0;
        end
      endcase
    end
  end

  // FSM state, counters and registered lock indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hit_cnt  <= hit_nxt;
      miss_cnt <= miss_nxt;
      locked   <= (state_nxt == LOCKED);
    end
  end

  // Stage 1: capture the raw word and whether it will be forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= bus_s.data_en & fwd_c;
      if (bus_s.data_en) begin
        s1_data <= bus_s.data;
      end
    end
  end

  // Stage 2: descramble into the output register; data holds between words.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_m.data    <= '0;
      bus_m.data_en <= 1'b0;
    end else begin
      bus_m.data_en <= s1_vld;
      if (s1_vld) begin
        bus_m.data.field0 <= unscramble(s1_data.field0);
        bus_m.data.field1 <= s1_data.field1;
        bus_m.data.field2 <= unscramble(s1_data.field2);
        bus_m.data.field3 <= unscramble(s1_data.field3);
      end
    end
  end

`ifdef DESCRAMBLER_STATS_EN
  // Saturating counts of lock losses and of accepted words that were dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      slip_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == LOCKED && state_nxt == HUNT && slip_cnt != 16'hFFFF) begin
        slip_cnt <= slip_cnt + 16'd1;
      end
      if (bus_s.data_en && !fwd_c && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_descrambler.sv
// Self-checking bench for descrambler: directed scenarios followed by random
// traffic, compared cycle by cycle against a behavioural alignment model.
module tb_descrambler;
  import descrambler_pkg::*;

  localparam int LOCK_CNT = 3;
  localparam int MISS_MAX = 2;

  logic clk;
  logic rst;
  logic locked;
`ifdef DESCRAMBLER_STATS_EN
  logic [15:0] slip_cnt;
  logic [15:0] drop_cnt;
`endif

  descrambler_if bus_in ();
  descrambler_if bus_out ();

  descrambler #(
    .SYNC_BYTE (8'hA5),
    .LOCK_CNT  (LOCK_CNT),
    .MISS_MAX  (MISS_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_s    (bus_in),
    .bus_m    (bus_out),
`ifdef DESCRAMBLER_STATS_EN
    .slip_cnt (slip_cnt),
    .drop_cnt (drop_cnt),
`endif
    .locked   (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit armed  = 0;

  // Behavioural model: consecutive-hit run while searching, consecutive misses while locked.
  bit      m_lock;
  int      m_run;
  int      m_miss;
  bit      m_p1_vld;
  packet_t m_p1_data;
  bit      m_out_en;
  packet_t m_out_data;
  int      m_slips;
  int      m_drops;

  function automatic logic [7:0] undo(input logic [7:0] b);
    return (b >= 8'd128) ? (b ^ 8'd1) : b;
  endfunction

  task automatic check_outputs();
    checks++;
    assert (bus_out.data_en === m_out_en) else begin
      fails++;
      $error("FAIL data_en got %b exp %b", bus_out.data_en, m_out_en);
    end
    checks++;
    assert (bus_out.data === m_out_data) else begin
      fails++;
      $error("FAIL data got %h exp %h", bus_out.data, m_out_data);
    end
    checks++;
    assert (locked === m_lock) else begin
      fails++;
      $error("FAIL locked got %b exp %b", locked, m_lock);
    end
`ifdef DESCRAMBLER_STATS_EN
    checks++;
    assert (slip_cnt === 16'(m_slips)) else begin
      fails++;
      $error("FAIL slip_cnt got %0d exp %0d", slip_cnt, m_slips);
    end
    checks++;
    assert (drop_cnt === 16'(m_drops)) else begin
      fails++;
      $error("FAIL drop_cnt got %0d exp %0d", drop_cnt, m_drops);
    end
`endif
  endtask

  // One cycle: check what the previous edge produced, then drive and predict the next edge.
  task automatic step(input logic r, input logic en, input packet_t d);
    bit match;
    bit fwd;
    @(negedge clk);
    if (armed) check_outputs();
    rst            = r;
    bus_in.data_en = en;
    bus_in.data    = d;
    if (r) begin
      m_lock = 0; m_run = 0; m_miss = 0;
      m_p1_vld = 0; m_p1_data = '0;
      m_out_en = 0; m_out_data = '0;
      m_slips = 0; m_drops = 0;
      armed = 1;
    end else begin
      m_out_en = m_p1_vld;
      if (m_p1_vld) begin
        m_out_data.field0 = undo(m_p1_data.field0);
        m_out_data.field1 = m_p1_data.field1;
        m_out_data.field2 = undo(m_p1_data.field2);
        m_out_data.field3 = undo(m_p1_data.field3);
      end
      fwd = 0;
      if (en) begin
        match = (d.field1 == 8'hA5);
        if (!m_lock) begin
          m_run = match ? m_run + 1 : 0;
          if (m_run >= LOCK_CNT) begin
            m_lock = 1; m_run = 0; m_miss = 0;
          end
        end else if (match) begin
          m_miss = 0; fwd = 1;
        end else begin
          m_miss++;
          if (m_miss >= MISS_MAX) begin
            m_lock = 0; m_miss = 0; m_run = 0; m_slips++;
          end else begin
            fwd = 1;
          end
        end
        if (!fwd) m_drops++;
        m_p1_data = d;
      end
      m_p1_vld = en && fwd;
    end
  endtask

  function automatic packet_t mk(input logic [7:0] f0, input logic [7:0] f1,
                                 input logic [7:0] f2, input logic [7:0] f3);
    packet_t p;
    p.field0 = f0; p.field1 = f1; p.field2 = f2; p.field3 = f3;
    return p;
  endfunction

  function automatic packet_t rnd(input logic [7:0] f1);
    packet_t p;
    p = packet_t'($urandom);
    p.field1 = f1;
    return p;
  endfunction

  initial begin
    packet_t p;
    rst = 1'b1;
    bus_in.data_en = 1'b0;
    bus_in.data = '0;

    // Reset, then acquire lock with five marker words.
    step(1, 0, '0);
    step(1, 0, '0);
    repeat (5) step(0, 1, mk(8'h81, 8'hA5, 8'h12, 8'hFF));
    repeat (3) step(0, 0, '0);
    checks++;
    assert (bus_out.data === mk(8'h80, 8'hA5, 8'h12, 8'hFE)) else begin
      fails++;
      $error("FAIL acquire_word got %h exp %h", bus_out.data, mk(8'h80, 8'hA5, 8'h12, 8'hFE));
    end

    // Lock loss: miss, hit, miss, miss.
    step(0, 1, rnd(8'h00));
    step(0, 1, rnd(8'hA5));
    step(0, 1, rnd(8'h00));
    step(0, 1, rnd(8'h00));
    repeat (3) step(0, 0, '0);

    // False start then relock.
    step(0, 1, rnd(8'hA5));
    step(0, 1, rnd(8'hA5));
    step(0, 1, rnd(8'h3C));
    step(0, 1, rnd(8'hA5));
    repeat (4) step(0, 1, rnd(8'hA5));

    // Gapped input while locked.
    step(0, 1, rnd(8'hA5));
    step(0, 0, rnd(8'h00));
    step(0, 0, rnd(8'h00));
    step(0, 1, rnd(8'hA5));
    repeat (3) step(0, 0, '0);

    // Reset with two words in flight, then fresh lock.
    step(0, 1, rnd(8'hA5));
    step(0, 1, rnd(8'hA5));
    step(1, 1, rnd(8'hA5));
    repeat (2) step(0, 0, '0);
    repeat (4) step(0, 1, rnd(8'hA5));
    repeat (3) step(0, 0, '0);

    // Random traffic with occasional gaps, misses and resets.
    for (int i = 0; i < 3000; i++) begin
      p = rnd(($urandom_range(0, 4) != 0) ? 8'hA5 : 8'($urandom));
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0, p);
    end
    repeat (3) step(0, 0, '0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
